// File: rtl/scalar_pkg.sv
// Shared opcodes, parcel field positions and types for the scalar shift issue block.
package scalar_pkg;

    localparam logic [6:0] OP_SHL = 7'o110;
    localparam logic [6:0] OP_SHR = 7'o111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 9;
    localparam int I_MSB  = 8;
    localparam int I_LSB  = 6;
    localparam int J_MSB  = 5;
    localparam int J_LSB  = 3;
    localparam int K_MSB  = 2;
    localparam int K_LSB  = 0;

    localparam int FU_LAT_DEF = 2;
    localparam int NUM_SREG   = 8;

    typedef logic [2:0]  sreg_idx_t;
    typedef logic [63:0] word_t;

    typedef struct packed {
        logic [6:0] op;
        sreg_idx_t  i;
        logic [2:0] j;
        logic [2:0] k;
    } parcel_t;

    typedef struct packed {
        logic      vld;
        sreg_idx_t i;
    } token_t;

    function automatic logic is_shift(input logic [6:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/scalar_shift_issue_if.sv
// Issue handshake and shift-unit bus between the parcel source/shift unit and the issue block.
interface scalar_shift_issue_if;
    import scalar_pkg::*;

    logic [15:0] i_Parcel;
    logic        i_Valid;
    logic        o_Ready;
    word_t       o_FU_Si;
    logic [2:0]  o_FU_j;
    logic [2:0]  o_FU_k;
    logic [6:0]  o_FU_Instr;
    word_t       i_FU_Si;

    modport slave (
        input  i_Parcel, i_Valid, i_FU_Si,
        output o_Ready, o_FU_Si, o_FU_j, o_FU_k, o_FU_Instr
    );

    modport master (
        output i_Parcel, i_Valid, i_FU_Si,
        input  o_Ready, o_FU_Si, o_FU_j, o_FU_k, o_FU_Instr
    );

endinterface

// File: rtl/scalar_sreg_file.sv
// Eight 64-bit S registers: writeback port beats the external port, two combinational reads.
module scalar_sreg_file
    import scalar_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_en_i,
    input  sreg_idx_t wb_addr_i,
    input  word_t     wb_data_i,
    input  logic      ext_en_i,
    input  sreg_idx_t ext_addr_i,
    input  word_t     ext_data_i,
    input  sreg_idx_t rd_a_addr_i,
    output word_t     rd_a_data_o,
    input  sreg_idx_t rd_b_addr_i,
    output word_t     rd_b_data_o
);

    word_t s_q [NUM_SREG];
    word_t s_d [NUM_SREG];

    always_comb begin
        s_d = s_q;
        if (ext_en_i) s_d[ext_addr_i] = ext_data_i;
        if (wb_en_i)  s_d[wb_addr_i]  = wb_data_i;
    end

    // NOTE: this array is reset because it is eight flops per bit, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) s_q <= '{default: '0};
        else     s_q <= s_d;
    end

    assign rd_a_data_o = s_q[rd_a_addr_i];
    assign rd_b_data_o = s_q[rd_b_addr_i];

endmodule

// File: rtl/scalar_shift_issue.sv
// Scalar shift issue stage: reserves S[i], drives the shift unit, writes results back FU_LAT later.
// Define SHIFT_FWD_EN to forward the arriving writeback into a same-cycle issue instead of stalling.
module scalar_shift_issue
    import scalar_pkg::*;
#(
    parameter int FU_LAT = FU_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    scalar_shift_issue_if.slave  bus,
    input  logic                 i_Wr_en,
    input  logic [2:0]           i_Wr_addr,
    input  logic [63:0]          i_Wr_data,
    input  logic [2:0]           i_Dbg_addr,
    output logic [63:0]          o_Dbg_data,
    output logic                 o_Illegal,
    output logic                 o_Wr_conflict
);

    parcel_t             pcl;
    logic                shift_op, blocked, issue, ext_ok;
    word_t               s_rd, operand;
    token_t              wb_tok;
    token_t              fu_tok_q, fu_tok_d;
    token_t              tok_q [FU_LAT];
    logic [NUM_SREG-1:0] resv_q, resv_d;
    word_t               fu_si_q, fu_si_d;
    logic [2:0]          fu_j_q, fu_j_d, fu_k_q, fu_k_d;
    logic [6:0]          fu_instr_q, fu_instr_d;
    logic                illegal_q, illegal_d, conflict_q, conflict_d;
`ifdef SHIFT_FWD_EN
    logic                wb_hit;
`endif

    assign wb_tok = tok_q[FU_LAT-1];

    scalar_sreg_file u_sreg (
        .clk         (clk),
        .rst         (rst),
        .wb_en_i     (wb_tok.vld),
        .wb_addr_i   (wb_tok.i),
        .wb_data_i   (bus.i_FU_Si),
        .ext_en_i    (ext_ok),
        .ext_addr_i  (i_Wr_addr),
        .ext_data_i  (i_Wr_data),
        .rd_a_addr_i (pcl.i),
        .rd_a_data_o (s_rd),
        .rd_b_addr_i (i_Dbg_addr),
        .rd_b_data_o (o_Dbg_data)
    );

    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        pcl.op   = bus.i_Parcel[OP_MSB:OP_LSB];
        pcl.i    = bus.i_Parcel[I_MSB:I_LSB];
        pcl.j    = bus.i_Parcel[J_MSB:J_LSB];
        pcl.k    = bus.i_Parcel[K_MSB:K_LSB];
        shift_op = is_shift(pcl.op);
`ifdef SHIFT_FWD_EN
        wb_hit   = wb_tok.vld && (wb_tok.i == pcl.i);
        blocked  = resv_q[pcl.i] && !wb_hit;
`else
        blocked  = resv_q[pcl.i];
`endif
        issue    = bus.i_Valid && shift_op && !blocked;
        ext_ok   = i_Wr_en && !resv_q[i_Wr_addr];

        operand = s_rd;
        if (ext_ok && (i_Wr_addr == pcl.i)) operand = i_Wr_data;
`ifdef SHIFT_FWD_EN
        if (wb_hit) operand = bus.i_FU_Si;
`endif

        // A new reservation on the writeback edge must survive that writeback's clear.
        resv_d = resv_q;
        if (wb_tok.vld) resv_d[wb_tok.i] = 1'b0;
        if (issue)      resv_d[pcl.i]    = 1'b1;

        fu_tok_d   = '{vld: issue, i: pcl.i};
        fu_instr_d = issue ? pcl.op  : '0;
        fu_si_d    = issue ? operand : '0;
        fu_j_d     = issue ? pcl.j   : '0;
        fu_k_d     = issue ? pcl.k   : '0;
        illegal_d  = bus.i_Valid && !shift_op;
        conflict_d = i_Wr_en && resv_q[i_Wr_addr];
    end

    assign bus.o_Ready = !(bus.i_Valid && shift_op && blocked);

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            resv_q     <= '0;
            fu_tok_q   <= '0;
            tok_q      <= '{default: '0};
            fu_instr_q <= '0;
            fu_si_q    <= '0;
            fu_j_q     <= '0;
            fu_k_q     <= '0;
            illegal_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            resv_q     <= resv_d;
            fu_tok_q   <= fu_tok_d;
            tok_q[0]   <= fu_tok_q;
            for (int s = 1; s < FU_LAT; s++) tok_q[s] <= tok_q[s-1];
            fu_instr_q <= fu_instr_d;
            fu_si_q    <= fu_si_d;
            fu_j_q     <= fu_j_d;
            fu_k_q     <= fu_k_d;
            illegal_q  <= illegal_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.o_FU_Instr = fu_instr_q;
    assign bus.o_FU_Si    = fu_si_q;
    assign bus.o_FU_j     = fu_j_q;
    assign bus.o_FU_k     = fu_k_q;
    assign o_Illegal      = illegal_q;
    assign o_Wr_conflict  = conflict_q;

endmodule
